// File: rtl/versat_seq_gen_pkg.sv
// Shared types and default widths for the Versat sequence generator.
package versat_seq_gen_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int DELAY_W_DEF  = 32;
  localparam int ITER_W_DEF   = 16;
  localparam int PERIOD_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    GEN    = 2'd2,
    FINISH = 2'd3
  } seq_state_t;

endpackage

// File: rtl/versat_seq_gen_loop.sv
// Two-level (outer i, inner j) loop counter; zero latency flags, advances on en, cleared on load.
// No backpressure of its own: en is the only stall input.
module versat_seq_gen_loop #(
  parameter int ITER_W   = 16,
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                en,
  input  logic [PERIOD_W-1:0] period,
  input  logic [ITER_W-1:0]   iterations,
  output logic                last_inner,
  output logic                last_all
);

  logic [PERIOD_W-1:0] j;
  logic [ITER_W-1:0]   i;

  // One extra bit so j+1 / i+1 never wrap before the compare.
  assign last_inner = !(({1'b0, j} + 1'b1) < {1'b0, period});
  assign last_all   = last_inner && !(({1'b0, i} + 1'b1) < {1'b0, iterations});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i <= '0;
      j <= '0;
    end else if (load) begin
      i <= '0;
      j <= '0;
    end else if (en) begin
      if (!last_inner) begin
        j <= j + 1'b1;
      end else begin
        j <= '0;
        if (!last_all) i <= i + 1'b1;
      end
    end
  end

endmodule

// File: rtl/versat_seq_gen.sv
// Versat source unit: after delay0 cycles emits period*iterations affine values on out0, then raises done.
// Latency: first value visible 1+delay0 cycles after run; running=0 freezes all progress.
module versat_seq_gen
  import versat_seq_gen_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DELAY_W  = DELAY_W_DEF,
  parameter int ITER_W   = ITER_W_DEF,
  parameter int PERIOD_W = PERIOD_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                running,
  input  logic                run,
  input  logic [DATA_W-1:0]   start,
  input  logic [DATA_W-1:0]   incr,
  input  logic [DATA_W-1:0]   shift,
  input  logic [PERIOD_W-1:0] period,
  input  logic [ITER_W-1:0]   iterations,
  input  logic [DELAY_W-1:0]  delay0,
  output logic [DATA_W-1:0]   out0,
  output logic                done
);

  seq_state_t          state;
  logic [DELAY_W-1:0]  dly;
  logic [DATA_W-1:0]   value;
  logic [DATA_W-1:0]   base;
  logic [DATA_W-1:0]   incr_q;
  logic [DATA_W-1:0]   shift_q;
  logic [PERIOD_W-1:0] period_q;
  logic [ITER_W-1:0]   iter_q;
  logic                last_inner;
  logic                last_all;
  logic                degen;
  logic                step;

  assign degen = (period_q == '0) || (iter_q == '0);
  assign step  = !run && running && (state == GEN) && !degen;

  versat_seq_gen_loop #(
    .ITER_W   (ITER_W),
    .PERIOD_W (PERIOD_W)
  ) u_loop (
    .clk        (clk),
    .rst        (rst),
    .load       (run),
    .en         (step),
    .period     (period_q),
    .iterations (iter_q),
    .last_inner (last_inner),
    .last_all   (last_all)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      dly      <= '0;
      value    <= '0;
      base     <= '0;
      incr_q   <= '0;
      shift_q  <= '0;
      period_q <= '0;
      iter_q   <= '0;
      out0     <= '0;
      done     <= 1'b1;
    end else if (run) begin
      // A run pulse always wins, discarding any sequence in flight.
      incr_q   <= incr;
      shift_q  <= shift;
      period_q <= period;
      iter_q   <= iterations;
      dly      <= delay0;
      base     <= start;
      value    <= start;
      done     <= 1'b0;
      state    <= (delay0 != '0) ? DELAY : GEN;
    end else if (running) begin
      case (state)
        DELAY: begin
          dly <= dly - 1'b1;
          if (dly == DELAY_W'(1)) state <= GEN;
        end
        GEN: begin
          if (degen) begin
            state <= FINISH;
          end else begin
            out0 <= value;
            if (!last_inner) begin
              value <= value + incr_q;
            end else if (!last_all) begin
              base  <= base + shift_q;
              value <= base + shift_q;
            end else begin
              state <= FINISH;
            end
          end
        end
        FINISH: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_versat_seq_gen.sv
// Directed bench for versat_seq_gen with hand-computed expected sequences.
module tb_versat_seq_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        running;
  logic        run;
  logic [31:0] start, incr, shift;
  logic [15:0] period, iterations;
  logic [31:0] delay0;
  logic [31:0] out0;
  logic        done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  versat_seq_gen dut (
    .clk        (clk),
    .rst        (rst),
    .running    (running),
    .run        (run),
    .start      (start),
    .incr       (incr),
    .shift      (shift),
    .period     (period),
    .iterations (iterations),
    .delay0     (delay0),
    .out0       (out0),
    .done       (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [31:0] s, input logic [31:0] inc, input logic [31:0] sh,
                     input logic [15:0] p, input logic [15:0] it, input logic [31:0] d);
    start = s; incr = inc; shift = sh; period = p; iterations = it; delay0 = d;
  endtask

  task automatic pulse_run();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  logic [31:0] basic_exp [6];
  logic [31:0] wrap_exp  [4];

  initial begin
    basic_exp = '{32'd10, 32'd12, 32'd14, 32'd110, 32'd112, 32'd114};
    wrap_exp  = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
    rst = 1'b0; running = 1'b1; run = 1'b0;
    cfg(0, 0, 0, 0, 0, 0);

    // Reset then idle
    repeat (3) tick();
    chk("rst_out0", out0, 0);
    chk("rst_done", {31'b0, done}, 1);
    rst = 1'b1;
    repeat (3) tick();
    chk("idle_out0", out0, 0);
    chk("idle_done", {31'b0, done}, 1);

    // Basic
    cfg(10, 2, 100, 3, 2, 0);
    pulse_run();
    chk("basic_done_low", {31'b0, done}, 0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("basic_v%0d", k), out0, basic_exp[k]);
    end
    tick();
    chk("basic_done", {31'b0, done}, 1);
    tick();
    chk("basic_hold", out0, 114);

    // Delay and wrap
    cfg(32'hFFFF_FFFE, 1, 0, 4, 1, 5);
    pulse_run();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("dly_hold%0d", k), out0, 114);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("wrap_v%0d", k), out0, wrap_exp[k]);
    end
    tick();
    chk("wrap_done", {31'b0, done}, 1);

    // Stall after the second value
    cfg(10, 2, 100, 3, 2, 0);
    pulse_run();
    tick(); chk("stall_v0", out0, 10);
    tick(); chk("stall_v1", out0, 12);
    running = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("stall_hold%0d", k), out0, 12);
      chk($sformatf("stall_done%0d", k), {31'b0, done}, 0);
    end
    running = 1'b1;
    for (int k = 2; k < 6; k++) begin
      tick();
      chk($sformatf("stall_v%0d", k), out0, basic_exp[k]);
    end
    tick();
    chk("stall_done", {31'b0, done}, 1);

    // Degenerate period = 0
    cfg(55, 1, 1, 0, 2, 0);
    pulse_run();
    chk("degen_busy", {31'b0, done}, 0);
    begin
      int n = 0;
      while (!done && n < 10) begin
        tick();
        n++;
      end
      chk("degen_done_in_budget", {31'b0, done}, 1);
    end
    chk("degen_out0", out0, 114);

    // Restart mid-sequence
    cfg(10, 2, 100, 3, 2, 0);
    pulse_run();
    tick(); chk("rs_v0", out0, 10);
    tick(); chk("rs_v1", out0, 12);
    cfg(7, 1, 0, 3, 1, 0);
    pulse_run();
    chk("rs_edge", out0, 12);
    tick(); chk("rs_new0", out0, 7);
    tick(); chk("rs_new1", out0, 8);

    // Async reset mid-GEN
    cfg(10, 2, 100, 3, 2, 0);
    pulse_run();
    tick(); tick();
    chk("ar_pre", out0, 12);
    #2 rst = 1'b0;
    #1;
    chk("ar_out0", out0, 0);
    chk("ar_done", {31'b0, done}, 1);
    tick();
    rst = 1'b1;
    repeat (4) tick();
    chk("ar_after_out0", out0, 0);
    chk("ar_after_done", {31'b0, done}, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/versat_seq_gen.md
Name: versat_seq_gen

Overview:
- Versat source unit: the producer end of the operand streams consumed by Versat arithmetic units such as the adder.
- Generates a two-level affine sequence on out0 after a programmable start delay.
- Signals completion on done.
- Configured by the Versat configuration bus; started by the accelerator's run/running control like every other unit.

Parameters:
- DATA_W, 32, width of out0, start, incr, shift.
- DELAY_W, 32, width of delay0 (cycles before first output).
- ITER_W, 16, width of iterations (outer loop count).
- PERIOD_W, 16, width of period (inner loop count).

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  reset. Asynchronous and active-low: asserted when 0, released synchronously to clk.
- running  input  1  accelerator running; when 0, all counters freeze.
- run  input  1  one-cycle start pulse; latches config and begins a sequence.
- start  input  DATA_W  first value.
- incr  input  DATA_W  inner-step increment.
- shift  input  DATA_W  outer-step increment, added to the outer base.
- period  input  PERIOD_W  inner loop count.
- iterations  input  ITER_W  outer loop count.
- delay0  input  DELAY_W  cycles between run and first value.
- out0  output  DATA_W  generated value, registered (versat_latency = 1 relative to internal step).
- done  output  1  high when idle or finished.

Behaviour:
- Reset:
  - out0 = 0, done = 1, state = IDLE.
  - All counters and latched config are cleared.
  - Reset asserted mid-sequence aborts immediately.
- States: IDLE, DELAY, GEN, FINISH.
- run = 1 (any state, running ignored on that cycle):
  - Latch start, incr, shift, period, iterations, delay0.
  - Set done = 0, base = start, value = start, i = 0, j = 0.
  - Go to DELAY if delay0 != 0, else GEN.
- run while not IDLE: restarts; the previous sequence is discarded.
- DELAY: decrement the delay counter each cycle with running = 1. At 0, go to GEN.
- GEN (each cycle with running = 1):
  - out0 <= value.
  - If j + 1 < period: j++, value += incr.
  - Else j = 0. If i + 1 < iterations: i++, base += shift, value = base + shift. Else go to FINISH.
- FINISH: done = 1, out0 holds its last value, go to IDLE.
- Timing: with run at cycle T and running held high, out0 = start is visible at T + 1 + delay0. Successive values follow on consecutive cycles.
- Total generated values = period * iterations.
- Degenerate counts: period = 0 or iterations = 0 emits no values (out0 unchanged). Go to FINISH after the delay.
- running = 0 in DELAY or GEN: counters, value and out0 hold; resume exactly where stopped.
- Arithmetic: unsigned modulo 2^DATA_W; wrap-around is silent.
- Loop counters are compared at full width; no overflow is possible.
- done is registered and rises the cycle after the last value is emitted.

Decomposition:
- Shared package versat_seq_gen_pkg:
  - State enum (IDLE, DELAY, GEN, FINISH).
  - Default width localparams.
- One sub-module, versat_seq_gen_loop: two-level counter (i, j) with enable, load and last-iteration flags.
- Top level holds the FSM, delay counter and value/base adders.

Test Plan:
- Reset then idle: rst = 0 for 3 cycles, release -> out0 = 0, done = 1, no change without run.
- Basic: start = 10, incr = 2, shift = 100, period = 3, iterations = 2, delay0 = 0, run at T, running = 1 -> out0 = 10, 12, 14, 110, 112, 114 at T+1..T+6; done = 1 at T+7.
- Delay and wrap: start = 0xFFFFFFFE, incr = 1, period = 4, iterations = 1, delay0 = 5 -> out0 = FFFFFFFE, FFFFFFFF, 0, 1 starting at T+6.
- Stall: same as Basic, running = 0 for 4 cycles after the second value -> out0 holds 12 for 4 cycles, then 14, 110, 112, 114; the total sequence is unchanged.
- Degenerate and restart: period = 0 -> done returns to 1 with no out0 change. Then run mid-sequence with start = 7, incr = 1 -> out0 restarts at 7 the next cycle.
- Async reset mid-GEN: drop rst between edges -> out0 = 0, done = 1 immediately; no further values until a new run.
